// File: rtl/cbus_arbiter_rr.sv
// rtl/cbus_arbiter_rr.sv - N-port CBus arbiter (round-robin or fixed priority), optional watchdog via CBUS_ARB_WATCHDOG_EN

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter_rr
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int PRIORITY_MODE   = 0,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t                    ireqs  [NUM_PORTS],
    output cbus_resp_t                   iresps [NUM_PORTS],
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         busy,
    output logic                         timeout
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || WATCHDOG_CYCLES < 1) begin : g_bad_params
        $error("cbus_arbiter_rr: NUM_PORTS must be >= 2 and WATCHDOG_CYCLES >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_ptr;

    logic               w_any_valid;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_next_ptr;
    int                 w_pos;

`ifdef CBUS_ARB_WATCHDOG_EN
    localparam int               WD_W    = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic               r_timeout;
    logic [WD_W-1:0]    r_wd_cnt;
`endif

    // Fixed priority always scans from port 0; round-robin scans from the pointer.
    assign w_start    = (PRIORITY_MODE != 0) ? '0 : r_ptr;
    assign w_next_ptr = (r_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : r_grant + IDX_W'(1);

    // Winner search: scan backwards so the first valid port in scan order is the last one written.
    always_comb begin
        w_any_valid = 1'b0;
        w_winner    = '0;
        w_pos       = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_pos = int'(w_start) + k;
            if (w_pos >= NUM_PORTS) begin
                w_pos = w_pos - NUM_PORTS;
            end
            if (ireqs[IDX_W'(w_pos)].valid) begin
                w_any_valid = 1'b1;
                w_winner    = IDX_W'(w_pos);
            end
        end
    end

    // Arbitration FSM: latch a winner in IDLE, hold the grant until the last beat (or watchdog expiry).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= '0;
`ifdef CBUS_ARB_WATCHDOG_EN
            r_timeout <= 1'b0;
            r_wd_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef CBUS_ARB_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                    if (w_any_valid) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        r_grant <= w_winner;
                    end
                end
                S_BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (PRIORITY_MODE == 0) begin
                            r_ptr <= w_next_ptr;
                        end
                    end
`ifdef CBUS_ARB_WATCHDOG_EN
                    else if (oresp.ready) begin
                        r_wd_cnt <= '0;
                    end else if (r_wd_cnt == WD_LAST) begin
                        // Slave went silent: abandon the burst, the requester never sees last.
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        if (PRIORITY_MODE == 0) begin
                            r_ptr <= w_next_ptr;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational pass-through while a grant is held; everything zero otherwise.
    always_comb begin
        oreq   = '0;
        iresps = '{default: '0};
        if (r_state == S_BUSY) begin
            oreq             = ireqs[r_grant];
            iresps[r_grant]  = oresp;
        end
    end

    assign grant_idx = r_grant;
    assign busy      = r_busy;

`ifdef CBUS_ARB_WATCHDOG_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// tb/tb_cbus_arbiter_rr.sv - randomized + directed bench for cbus_arbiter_rr against a behavioural model

module tb_cbus_arbiter_rr;
    import cbus_pkg::*;

    localparam int N  = 4;
    localparam int WD = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    cbus_req_t  ireqs [N];
    cbus_resp_t oresp;

    cbus_resp_t rr_iresps [N];
    cbus_resp_t fp_iresps [N];
    cbus_req_t  rr_oreq, fp_oreq;
    logic [1:0] rr_grant, fp_grant;
    logic       rr_busy, fp_busy, rr_to, fp_to;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = round-robin DUT, index 1 = fixed-priority DUT.
    bit m_busy  [2];
    int m_grant [2];
    int m_ptr   [2];
    bit m_to    [2];
    int m_wd    [2];

    always #5 clk = ~clk;

    cbus_arbiter_rr #(.NUM_PORTS(N), .PRIORITY_MODE(0), .WATCHDOG_CYCLES(WD)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(rr_iresps),
        .oreq(rr_oreq), .oresp(oresp), .grant_idx(rr_grant), .busy(rr_busy), .timeout(rr_to)
    );

    cbus_arbiter_rr #(.NUM_PORTS(N), .PRIORITY_MODE(1), .WATCHDOG_CYCLES(WD)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(fp_iresps),
        .oreq(fp_oreq), .oresp(oresp), .grant_idx(fp_grant), .busy(fp_busy), .timeout(fp_to)
    );

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m]  = 1'b0;
            m_grant[m] = 0;
            m_ptr[m]   = 0;
            m_to[m]    = 1'b0;
            m_wd[m]    = 0;
        end
    endtask

    function automatic int pick(input int m);
        int start;
        start = (m == 1) ? 0 : m_ptr[m];
        for (int k = 0; k < N; k++) begin
            logic [1:0] ix;
            ix = 2'((start + k) % N);
            if (ireqs[ix].valid) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic finish_burst(input int m);
        m_busy[m] = 1'b0;
        if (m == 0) m_ptr[m] = (m_grant[m] + 1) % N;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (!m_busy[m]) begin
                int w;
                w = pick(m);
                if (w >= 0) begin
                    m_busy[m]  = 1'b1;
                    m_grant[m] = w;
                    m_wd[m]    = 0;
                end
            end else if (oresp.ready && oresp.last) begin
                finish_burst(m);
            end else begin
`ifdef CBUS_ARB_WATCHDOG_EN
                if (oresp.ready) begin
                    m_wd[m] = 0;
                end else begin
                    m_wd[m]++;
                    if (m_wd[m] >= WD) begin
                        m_to[m] = 1'b1;
                        finish_burst(m);
                    end
                end
`endif
            end
        end
    endtask

    task automatic check_dut(input int m);
        cbus_req_t  ao, eo;
        cbus_resp_t ar [N];
        cbus_resp_t er;
        logic [1:0] ag, g;
        logic       ab, at;
        string      tag;
        if (m == 0) begin
            ao = rr_oreq; ag = rr_grant; ab = rr_busy; at = rr_to; ar = rr_iresps; tag = "rr";
        end else begin
            ao = fp_oreq; ag = fp_grant; ab = fp_busy; at = fp_to; ar = fp_iresps; tag = "fp";
        end
        g  = 2'(m_grant[m]);
        eo = m_busy[m] ? ireqs[g] : '0;
        cmp({tag, ".busy"},    128'(ab), 128'(m_busy[m]));
        cmp({tag, ".grant"},   128'(ag), 128'(g));
        cmp({tag, ".timeout"}, 128'(at), 128'(m_to[m]));
        cmp({tag, ".oreq"},    128'(ao), 128'(eo));
        for (int i = 0; i < N; i++) begin
            er = (m_busy[m] && i == m_grant[m]) ? oresp : '0;
            cmp($sformatf("%s.iresps[%0d]", tag, i), 128'(ar[2'(i)]), 128'(er));
        end
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        #1;
        if (reset) model_reset();
        check_dut(0);
        check_dut(1);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input bit v, input int len);
        logic [1:0] ix;
        ix = 2'(p);
        if (v) begin
            ireqs[ix].valid    = 1'b1;
            ireqs[ix].is_write = 1'($urandom);
            ireqs[ix].size     = 3'($urandom);
            ireqs[ix].addr     = $urandom;
            ireqs[ix].data     = $urandom;
            ireqs[ix].len      = 8'(len);
        end else begin
            ireqs[ix] = '0;
        end
    endtask

    task automatic set_resp(input bit rdy, input bit lst);
        oresp.ready = rdy;
        oresp.last  = lst;
        oresp.data  = $urandom;
    endtask

    task automatic clear_all();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 0);
        set_resp(1'b0, 1'b0);
    endtask

    int rr_q [$];
    bit r;
    int exp_to;

    initial begin
        clear_all();
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp("rst.rr_busy",    128'(rr_busy),       128'(0));
        cmp("rst.rr_grant",   128'(rr_grant),      128'(0));
        cmp("rst.rr_timeout", 128'(rr_to),         128'(0));
        cmp("rst.rr_oreq",    128'(rr_oreq),       128'(0));
        cmp("rst.fp_busy",    128'(fp_busy),       128'(0));
        tick();
        reset = 1'b0;

        // Two ports, single beats: round-robin must alternate with an IDLE cycle between grants.
        set_port(0, 1'b1, 0);
        set_port(1, 1'b1, 0);
        set_resp(1'b1, 1'b1);
        repeat (8) begin
            tick();
            if (rr_busy) rr_q.push_back(int'(rr_grant));
        end
        cmp("alt.count", 128'(rr_q.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("alt.grant%0d", i), 128'((i < rr_q.size()) ? rr_q[i] : -1), 128'(i % 2));
        end

        // Drive ptr to 3, then ports 0 and 2: wrap-around picks 0, ptr then becomes 1.
        set_port(0, 1'b0, 0);
        set_port(1, 1'b0, 0);
        set_port(2, 1'b1, 0);
        tick();
        tick();
        set_port(0, 1'b1, 0);
        tick();
        cmp("wrap.rr_grant", 128'(rr_grant), 128'(0));
        cmp("wrap.rr_busy",  128'(rr_busy),  128'(1));
        tick();
        set_port(1, 1'b1, 0);
        set_port(3, 1'b1, 0);
        tick();
        cmp("wrap.ptr1_grant", 128'(rr_grant), 128'(1));
        tick();

        // Fixed priority with ports 1 and 3 requesting forever: only port 1 is served.
        clear_all();
        set_port(1, 1'b1, 0);
        set_port(3, 1'b1, 0);
        set_resp(1'b1, 1'b1);
        repeat (6) begin
            tick();
            if (fp_busy) cmp("fp.grant_port1", 128'(fp_grant), 128'(1));
        end

        // Four-beat burst on port 1, port 0 shows up mid-burst.
        clear_all();
        tick();
        set_port(1, 1'b1, 3);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_resp(1'b1, b == 3);
            if (b == 1) set_port(0, 1'b1, 0);
            tick();
        end
        cmp("burst.idle_after_last", 128'(rr_busy), 128'(0));
        set_port(1, 1'b0, 0);
        set_resp(1'b0, 1'b0);
        tick();
        cmp("burst.rr_next_grant", 128'(rr_grant), 128'(0));
        cmp("burst.rr_next_busy",  128'(rr_busy),  128'(1));
        cmp("burst.fp_next_grant", 128'(fp_grant), 128'(0));
        set_resp(1'b1, 1'b1);
        tick();
        clear_all();
        tick();

        // Put ptr at 3, start a burst, reset in beat 2: afterwards lowest valid port wins.
        set_port(2, 1'b1, 0);
        set_resp(1'b1, 1'b1);
        tick();
        tick();
        clear_all();
        set_port(1, 1'b1, 3);
        set_port(3, 1'b1, 3);
        tick();
        cmp("rstmid.rr_grant_pre", 128'(rr_grant), 128'(3));
        set_resp(1'b1, 1'b0);
        tick();
        set_resp(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        cmp("rstmid.rr_busy",   128'(rr_busy),       128'(0));
        cmp("rstmid.rr_valid",  128'(rr_oreq.valid), 128'(0));
        cmp("rstmid.fp_busy",   128'(fp_busy),       128'(0));
        tick();
        reset = 1'b0;
        set_resp(1'b0, 1'b0);
        tick();
        cmp("rstmid.rr_first_grant", 128'(rr_grant), 128'(1));
        set_resp(1'b1, 1'b1);
        tick();
        clear_all();
        tick();

        // Silent slave: watchdog fires after WD busy cycles when compiled in.
        set_port(1, 1'b1, 0);
        set_resp(1'b0, 1'b0);
        repeat (12) tick();
`ifdef CBUS_ARB_WATCHDOG_EN
        exp_to = 1;
`else
        exp_to = 0;
`endif
        cmp("wd.rr_timeout", 128'(rr_to),   128'(exp_to));
        cmp("wd.fp_timeout", 128'(fp_to),   128'(exp_to));
        cmp("wd.rr_busy",    128'(rr_busy), 128'(1));
        set_port(1, 1'b0, 0);
        repeat (3) tick();
        cmp("wd.rr_timeout_sticky", 128'(rr_to), 128'(exp_to));

        // Random traffic, periodic stalls and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (ireqs[2'(p)].valid) begin
                    if ($urandom_range(7) == 0) set_port(p, 1'b0, 0);
                end else if ($urandom_range(2) == 0) begin
                    set_port(p, 1'b1, int'($urandom_range(3)));
                end
            end
            if ((cyc % 500) >= 488) begin
                set_resp(1'b0, 1'b0);
            end else begin
                r = ($urandom_range(3) != 0);
                set_resp(r, r && ($urandom_range(2) == 0));
            end
            reset = ((cyc % 700) == 699);
            tick();
        end

        reset = 1'b1;
        tick();
        cmp("end.rr_timeout_cleared", 128'(rr_to), 128'(0));
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter_rr.md
# cbus_arbiter_rr

Parametrised N-port CBus arbiter. It multiplexes NUM_PORTS cbus requesters (instruction converter, data converter, DMA, PTW, …) onto the single outer CBus port leaving VTop. It selects requesters by round-robin or fixed priority and holds each grant for a whole burst until the last beat. An optional watchdog releases a grant whose slave never responds.

## Interface
- NUM_PORTS, default 2: number of requesters; at least 2.
- PRIORITY_MODE, default 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
- WATCHDOG_CYCLES, default 1024: number of consecutive no-ready cycles in BUSY before a timeout; used only with the watchdog macro.
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- ireqs, in, cbus_req_t[NUM_PORTS]: requester requests; index 0 is the highest fixed priority.
- iresps, out, cbus_resp_t[NUM_PORTS]: per-requester responses.
- oreq, out, cbus_req_t: request to the outer bus.
- oresp, in, cbus_resp_t: response from the outer bus.
- grant_idx, out, $clog2(NUM_PORTS): registered index of the granted port.
- busy, out, 1: high while in BUSY.
- timeout, out, 1: sticky watchdog flag; tied to 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - oreq is all-zero and every iresps entry is all-zero.
  - If any ireqs[i].valid is set, latch the winner into grant_idx and go to BUSY on the next edge.
- Round-robin winner: the first valid index found by scanning ptr, ptr+1, … modulo NUM_PORTS.
- Fixed-priority winner: the lowest valid index; ptr is ignored.
- BUSY:
  - oreq = ireqs[grant_idx], passed through combinationally.
  - iresps[grant_idx] = oresp.
  - All other iresps entries are all-zero.
- Completion: when oresp.ready && oresp.last in BUSY, go to IDLE.
  - In round-robin mode, ptr ← (grant_idx+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- The requester must hold valid and the request fields stable until it sees ready&&last. The arbiter never aborts a burst on valid deassertion; if valid drops mid-burst, oreq.valid follows it and the grant is kept.
- Requests arriving while BUSY are ignored until the next IDLE cycle.
- After every completion the arbiter spends at least one IDLE cycle. This lets the finished requester drop valid before it can be re-selected.
- Reset values: state IDLE, ptr 0, grant_idx 0, busy 0, timeout 0, oreq zero, iresps zero.
- Asserting reset mid-burst returns the arbiter to IDLE immediately. The outer slave must be reset alongside it.

## Timing
- Arbitration latency: oreq.valid goes high exactly 1 cycle after a valid request is seen in IDLE.
- Request and response paths are combinational in BUSY; no added beat latency.
- Back-to-back bursts from different ports are separated by exactly 1 IDLE cycle.
- A single-beat transaction (len = 0, ready&&last in the first BUSY cycle) occupies 2 cycles: IDLE then BUSY.
- grant_idx and busy change only on clk edges.

## Configuration
- CBUS_ARB_WATCHDOG_EN defined:
  - A counter clears on entering BUSY and on any oresp.ready.
  - It increments on every other BUSY cycle.
  - When it reaches WATCHDOG_CYCLES: timeout is set (sticky until reset), the FSM goes to IDLE, ptr advances as on a normal completion, and the granted requester never sees last.
- CBUS_ARB_WATCHDOG_EN undefined: no counter logic, timeout is constant 0, and BUSY lasts indefinitely.

## Test plan
- NUM_PORTS=2, round-robin, ports 0 and 1 both valid continuously with single-beat transactions:
  - grants alternate 0,1,0,1.
  - each oreq.valid is preceded by one IDLE cycle.
  - the non-granted iresps entry stays zero.
- NUM_PORTS=4, PRIORITY_MODE=1, ports 1 and 3 valid: port 1 is granted.
  - Port 1 keeps requesting after each completion → port 3 is never granted while port 1 stays valid.
- NUM_PORTS=4, round-robin, ptr=3, ports 0 and 2 valid → port 0 is granted (wrap-around); ptr becomes 1 after completion.
- Burst len=3 (4 beats) on port 1, with port 0 raising valid mid-burst:
  - oreq follows port 1 for all 4 beats.
  - port 0 is granted 1 cycle after the beat with last.
- Reset asserted during beat 2 of a burst: busy=0 and oreq.valid=0 asynchronously; after reset release, the first grant goes to the lowest valid index (ptr=0).
- Watchdog with WATCHDOG_CYCLES=8, oresp.ready held at 0:
  - timeout rises after 8 BUSY cycles and the FSM returns to IDLE.
  - timeout stays 1 until reset.
  - without the macro, busy stays 1.
